// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state type and encodings for the hazard controller
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: execute-operand forward select; the memory stage wins over writeback, x0 never forwards
// ports: rs (execute source), rd_m/reg_write_m (memory dest), rd_w/reg_write_w (writeback dest), fwd (select)
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);
  always_comb
    fwd = (reg_write_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
          (reg_write_w && rd_w != '0 && rd_w == rs) ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control with a data-memory wait timeout FSM
// ports: clk, reset (async, active-low); decode/execute/memory/writeback register ids and
// controls in; Stall*/Flush* stage-register enables, ForwardAE/BE selects and mem_fault pulse out.
// HAZARD_PERF_EN adds stall_cycles and flush_events counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       dmem_ready,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] fwd_a, fwd_b;
  logic fault, mem_stall, branch, lw_stall, lw;
  hazard_fwd_unit u_fwd_a (.rs(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_a));
  hazard_fwd_unit u_fwd_b (.rs(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_b));
  assign fault     = state == ST_FAULT;
  assign lw_stall  = ResultSrcE == RESULT_LOAD && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign mem_stall = !fault && MemReqM && !dmem_ready;
  // a taken branch squashes the load's dependent, so it overrides the load-use stall
  assign branch    = !fault && !mem_stall && PCSrcE;
  assign lw        = !fault && !mem_stall && !PCSrcE && lw_stall;
  // reset forces the bubble-loading flushes on without waiting for a clock
  always_comb begin
    StallF    = reset && (mem_stall || lw);
    StallD    = reset && (mem_stall || lw);
    StallE    = reset && mem_stall;
    StallM    = reset && mem_stall;
    FlushD    = !reset || fault || branch;
    FlushE    = !reset || fault || branch || lw;
    FlushW    = !reset || fault || mem_stall;
    ForwardAE = reset ? fwd_a : FWD_RF;
    ForwardBE = reset ? fwd_b : FWD_RF;
    mem_fault = reset && fault;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_RUN:
          if (mem_stall) begin
            state <= ST_WAIT;
            cnt   <= CW'(1);
          end
        ST_WAIT:
          if (dmem_ready) state <= ST_RUN;
          else if (cnt == CW'(MEM_TIMEOUT)) state <= ST_FAULT;
          else cnt <= cnt + CW'(1);
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallF || StallD || StallE || StallM) stall_cycles <= stall_cycles + 32'd1;
      if (branch || fault) flush_events <= flush_events + 32'd1;
    end
`endif
endmodule
